// File: rtl/ram_bus_bridge.sv
// Bridges the CPU MEM-stage data port to an asynchronous 32-bit SRAM.
// It stalls the pipeline for a fixed number of wait cycles on every access.
module ram_bus_bridge #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_o,
  output logic [17:0] sram_addr_o,
  output logic [31:0] sram_data_o,
  output logic        sram_data_oe_o,
  input  logic [31:0] sram_data_i,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [3:0]  sram_be_n_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        stall_int;

  // Byte offset and upper address bits are outside the 1 MiB SRAM window.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr_i[31:20], cpu_addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cpu_ce_i) begin
            addr_q  <= cpu_addr_i[19:2];
            wdata_q <= cpu_data_i;
            sel_q   <= cpu_sel_i;
            we_q    <= cpu_we_i;
            count   <= WAIT_LOAD;
          end
        end
        ACCESS: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else if (!we_q) begin
            rdata_q <= sram_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are only ever active in ACCESS; DONE gives address/data hold time.
  always_comb begin
    state_next     = state;
    stall_int      = 1'b0;
    sram_ce_n_o    = 1'b1;
    sram_oe_n_o    = 1'b1;
    sram_we_n_o    = 1'b1;
    sram_data_oe_o = 1'b0;
    sram_be_n_o    = 4'b1111;
    case (state)
      IDLE: begin
        if (cpu_ce_i) begin
          stall_int  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall_int   = 1'b1;
        sram_ce_n_o = 1'b0;
        if (we_q) begin
          sram_we_n_o    = 1'b0;
          sram_data_oe_o = 1'b1;
          sram_be_n_o    = ~sel_q;
        end else begin
          sram_oe_n_o = 1'b0;
          sram_be_n_o = 4'b0000;
        end
        if (count == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign stall_o     = stall_int & ~rst;
  assign sram_addr_o = addr_q;
  assign sram_data_o = wdata_q;
  assign cpu_data_o  = rdata_q;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Self-checking bench for ram_bus_bridge: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance, directed and random accesses compared cycle by cycle to a timing model.
module tb_ram_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] sram_rd;
  bit          inst;

  logic        ce_a, ce_b;
  logic [31:0] a_cpu_data, b_cpu_data, a_wdata, b_wdata;
  logic [17:0] a_addr, b_addr;
  logic        a_stall, b_stall, a_oe, b_oe;
  logic        a_ce_n, a_oe_n, a_we_n, b_ce_n, b_oe_n, b_we_n;
  logic [3:0]  a_be_n, b_be_n;

  logic [31:0] o_cpu_data, o_wdata;
  logic [17:0] o_addr;
  logic        o_stall;
  logic [7:0]  o_strb;

  int checks = 0;
  int errors = 0;

  logic        t_we;
  logic [3:0]  t_sel;
  logic [31:0] t_addr;
  logic [31:0] t_data;
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  assign ce_a = cpu_ce & (inst == 1'b0);
  assign ce_b = cpu_ce & (inst == 1'b1);

  ram_bus_bridge #(.WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .cpu_ce_i(ce_a), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata), .cpu_data_o(a_cpu_data),
    .stall_o(a_stall), .sram_addr_o(a_addr), .sram_data_o(a_wdata),
    .sram_data_oe_o(a_oe), .sram_data_i(sram_rd), .sram_ce_n_o(a_ce_n),
    .sram_oe_n_o(a_oe_n), .sram_we_n_o(a_we_n), .sram_be_n_o(a_be_n)
  );

  ram_bus_bridge #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .cpu_ce_i(ce_b), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata), .cpu_data_o(b_cpu_data),
    .stall_o(b_stall), .sram_addr_o(b_addr), .sram_data_o(b_wdata),
    .sram_data_oe_o(b_oe), .sram_data_i(sram_rd), .sram_ce_n_o(b_ce_n),
    .sram_oe_n_o(b_oe_n), .sram_we_n_o(b_we_n), .sram_be_n_o(b_be_n)
  );

  always_comb begin
    if (inst) begin
      o_cpu_data = b_cpu_data;
      o_wdata    = b_wdata;
      o_addr     = b_addr;
      o_stall    = b_stall;
      o_strb     = {b_ce_n, b_oe_n, b_we_n, b_oe, b_be_n};
    end else begin
      o_cpu_data = a_cpu_data;
      o_wdata    = a_wdata;
      o_addr     = a_addr;
      o_stall    = a_stall;
      o_strb     = {a_ce_n, a_oe_n, a_we_n, a_oe, a_be_n};
    end
  end

  task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s (inst %0d cycle %0d): observed %h expected %h", tag, inst, c, obs, exp);
      $error("[TB] check %s failed", tag);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [3:0] sel,
                                input logic [31:0] addr, input logic [31:0] data);
    t_we = we; t_sel = sel; t_addr = addr; t_data = data;
    cpu_we = we; cpu_sel = sel; cpu_addr = addr; cpu_wdata = data; cpu_ce = 1'b1;
  endtask

  // Cycle c counts from the request cycle: 0 = request, 1..W+1 = access, W+2 = done.
  task automatic check_output(input int c, input logic [31:0] rd);
    int          w;
    logic        acc;
    logic [7:0]  exp_strb;
    logic [31:0] exp_cpu;
    w = inst ? 0 : 2;
    acc = (c >= 1) && (c <= w + 1);
    exp_strb = {~acc, ~(acc & ~t_we), ~(acc & t_we), acc & t_we,
                acc ? (t_we ? ~t_sel : 4'h0) : 4'hF};
    exp_cpu = (c == w + 2 && !t_we) ? rd : exp_rd[inst];
    check("stall", c, {31'd0, o_stall}, {31'd0, c <= w + 1});
    check("strobes", c, {24'd0, o_strb}, {24'd0, exp_strb});
    check("cpu_data", c, o_cpu_data, exp_cpu);
    if (c >= 1) begin
      check("sram_addr", c, {14'd0, o_addr}, {14'd0, t_addr[19:2]});
      check("sram_wdata", c, o_wdata, t_data);
    end
  endtask

  // Runs one access whose request is already on the inputs; cpu inputs are
  // scrambled while busy, and the SRAM word is only valid in the last access cycle.
  task automatic run_txn(input logic [31:0] rd, input bit chain, input logic n_we,
                         input logic [3:0] n_sel, input logic [31:0] n_addr,
                         input logic [31:0] n_data);
    int w;
    w = inst ? 0 : 2;
    for (int c = 0; c <= w + 2; c++) begin
      @(negedge clk);
      check_output(c, rd);
      @(posedge clk);
      #1;
      if (c <= w) begin
        cpu_ce = 1'($urandom); cpu_we = 1'($urandom); cpu_sel = 4'($urandom);
        cpu_addr = $urandom; cpu_wdata = $urandom;
        sram_rd = (c == w) ? rd : $urandom;
      end else if (c == w + 1) begin
        sram_rd = $urandom;
        if (chain) begin
          cpu_we = n_we; cpu_sel = n_sel; cpu_addr = n_addr; cpu_wdata = n_data; cpu_ce = 1'b1;
        end else begin
          cpu_ce = 1'b0;
        end
      end
    end
    if (!t_we) exp_rd[inst] = rd;
    if (chain) begin
      t_we = n_we; t_sel = n_sel; t_addr = n_addr; t_data = n_data;
    end
  endtask

  initial begin
    bit          pending;
    logic        n_we;
    logic [3:0]  n_sel;
    logic [31:0] n_addr, n_data;

    rst = 1'b1; inst = 1'b0; cpu_ce = 1'b1; cpu_we = 1'b0; cpu_sel = 4'hF;
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0; sram_rd = 32'h0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    #2;
    check("rst_stall", 0, {31'd0, o_stall}, 32'd0);
    check("rst_strobes", 0, {24'd0, o_strb}, 32'h0000_00EF);
    check("rst_cpu_data", 0, o_cpu_data, 32'h0);
    check("rst_addr", 0, {14'd0, o_addr}, 32'h0);
    inst = 1'b1;
    #1;
    check("rst_stall_b", 0, {31'd0, o_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_ce = 1'b0; inst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed read, 2 wait cycles");
    apply_stimulus(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    run_txn(32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("[TB] directed byte write");
    apply_stimulus(1'b1, 4'b0010, 32'h0000_0104, 32'h0000_AB00);
    run_txn(32'h1111_2222, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("[TB] back-to-back write then read");
    apply_stimulus(1'b1, 4'hF, 32'hFFF0_0202, 32'h1234_5678);
    run_txn(32'h5555_AAAA, 1'b1, 1'b0, 4'hF, 32'hFFF0_0202, 32'h1234_5678);
    run_txn(32'hCAFE_F00D, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("[TB] write with no lanes selected");
    apply_stimulus(1'b1, 4'b0000, 32'h0000_0300, 32'h9999_9999);
    run_txn(32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("[TB] zero-wait read");
    inst = 1'b1;
    apply_stimulus(1'b0, 4'hF, 32'h000F_FFFC, 32'h0);
    run_txn(32'h0BAD_CAFE, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("[TB] random traffic");
    for (int k = 0; k < 2; k++) begin
      inst = k[0];
      pending = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (!pending) apply_stimulus(1'($urandom), 4'($urandom), $urandom, $urandom);
        pending = (i != 9) && ($urandom_range(0, 2) == 0);
        n_we = 1'($urandom); n_sel = 4'($urandom); n_addr = $urandom; n_data = $urandom;
        run_txn($urandom, pending, n_we, n_sel, n_addr, n_data);
      end
    end

    $display("[TB] reset during second access cycle of a write");
    inst = 1'b0;
    apply_stimulus(1'b1, 4'hF, 32'h0000_0400, 32'h7777_7777);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1; cpu_ce = 1'b1;
    #1;
    check("mid_rst_stall", 2, {31'd0, o_stall}, 32'd0);
    check("mid_rst_strobes", 2, {24'd0, o_strb}, 32'h0000_00EF);
    check("mid_rst_cpu_data", 2, o_cpu_data, 32'h0);
    check("mid_rst_addr", 2, {14'd0, o_addr}, 32'h0);
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0; cpu_ce = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_stall", c, {31'd0, o_stall}, 32'd0);
      check("post_rst_strobes", c, {24'd0, o_strb}, 32'h0000_00EF);
      check("post_rst_cpu_data", c, o_cpu_data, 32'h0);
    end
    @(posedge clk); #1;
    apply_stimulus(1'b0, 4'hF, 32'h0000_0404, 32'h0);
    run_txn(32'hA5A5_5A5A, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bus_bridge.md
RAM_BUS_BRIDGE -- requirements
Module: ram_bus_bridge

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning extra SRAM wait cycles per access (legal range 0..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port cpu_ce_i  input  1  CPU data-memory request valid.
REQ-005 SHALL have port cpu_we_i  input  1  1 = write, 0 = read.
REQ-006 SHALL have port cpu_sel_i  input  4  byte lane select; bit n covers data[8n+7:8n].
REQ-007 SHALL have port cpu_addr_i  input  32  byte address.
REQ-008 SHALL have port cpu_data_i  input  32  store data.
REQ-009 SHALL have port cpu_data_o  output  32  load data returned to the CPU MEM stage.
REQ-010 SHALL have port stall_o  output  1  pipeline stall request to the CPU.
REQ-011 SHALL have port sram_addr_o  output  18  SRAM word address.
REQ-012 SHALL have port sram_data_o  output  32  SRAM write data.
REQ-013 SHALL have port sram_data_oe_o  output  1  write-data drive enable for the pad tristate.
REQ-014 SHALL have port sram_data_i  input  32  SRAM read data.
REQ-015 SHALL have ports sram_ce_n_o, sram_oe_n_o, sram_we_n_o  output  1 each  active-low SRAM strobes.
REQ-016 SHALL have port sram_be_n_o  output  4  active-low SRAM byte enables.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-018 IDLE with cpu_ce_i=1: SHALL latch addr[19:2], data, sel, we; load counter with WAIT_CYCLES; next state ACCESS.
REQ-019 IDLE with cpu_ce_i=0: SHALL stay IDLE, all strobes inactive.
REQ-020 stall_o SHALL be combinational: 1 when (state=IDLE and cpu_ce_i=1) or state=ACCESS; 0 in DONE and in idle IDLE.
REQ-021 ACCESS: sram_ce_n_o=0; read -> sram_oe_n_o=0, sram_be_n_o=4'b0000; write -> sram_we_n_o=0, sram_data_oe_o=1, sram_be_n_o=~latched sel.
REQ-022 ACCESS: counter SHALL decrement each cycle while nonzero; at counter=0 next state DONE, and a read SHALL capture sram_data_i into the load-data register on that edge.
REQ-023 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles; DONE exactly 1 cycle, then IDLE.
REQ-024 Total stall SHALL be WAIT_CYCLES+2 cycles from the request cycle; stall_o low in DONE so the CPU advances on the DONE edge.
REQ-025 DONE: all strobes inactive; sram_addr_o and sram_data_o SHALL hold latched values (hold time after we_n rise).
REQ-026 cpu_data_o SHALL show the captured word from DONE until the next read capture; writes SHALL NOT alter it.
REQ-027 cpu_* input changes during ACCESS/DONE SHALL be ignored; a request present in the IDLE cycle after DONE SHALL start a new access (back-to-back allowed, one IDLE cycle between).
REQ-028 Write with cpu_sel_i=4'b0000 SHALL run the full FSM timing with sram_be_n_o=4'b1111 (no byte written).
REQ-029 cpu_addr_i[1:0] and [31:20] SHALL be ignored; no alignment fault is raised.
REQ-030 WAIT_CYCLES=0 SHALL give ACCESS of 1 cycle, stall of 2 cycles.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, counter 0, all latched registers and cpu_data_o to 0, ce_n/oe_n/we_n=1, be_n=4'b1111, sram_data_oe_o=0, stall_o=cpu_ce_i-independent 0 while rst=1.
REQ-032 rst asserted mid-ACCESS SHALL abort the access with no further strobe; after rst falls the bridge SHALL start only on a fresh cpu_ce_i in IDLE.

Verification
REQ-033 Read, WAIT_CYCLES=2: ce=1,we=0,addr=0x0000_0010, sram_data_i=0xDEAD_BEEF -> sram_addr_o=0x00004, oe_n low 3 cycles, stall_o high 4 cycles, cpu_data_o=0xDEAD_BEEF in DONE.
REQ-034 Byte write: we=1,sel=4'b0010,addr=0x0000_0104,data=0x0000_AB00 -> be_n=4'b1101, we_n low 3 cycles, sram_data_o=0x0000_AB00, oe_n stays high.
REQ-035 Back-to-back: write then read at same address held on inputs -> two accesses separated by exactly one IDLE cycle; cpu_data_o unchanged by the write.
REQ-036 WAIT_CYCLES=0 read -> stall_o high exactly 2 cycles, data captured after 1 ACCESS cycle.
REQ-037 rst pulse during 2nd ACCESS cycle of a write -> we_n and ce_n high within the reset cycle, stall_o=0, cpu_data_o=0, no DONE state.
REQ-038 Write sel=4'b0000 -> full 4-cycle stall, be_n=4'b1111 throughout.
